// File: rtl/accum_fp_pkg.sv
// accum_fp_pkg: shared widths, exponent constants and beat layout for the accumulator normaliser
package accum_fp_pkg;

    localparam int DEF_EXPONENT_WIDTH = 8;
    localparam int DEF_MANTISSA_WIDTH = 23;
    localparam int DEF_ROUNDING_BITS  = 3;
    localparam int DEF_ACC_WIDTH      = 48;

    // Count width able to represent 0..w inclusive (w itself means "all zero").
    function automatic int lzc_width(input int w);
        return $clog2(w + 1);
    endfunction

    function automatic int exp_all_ones(input int e);
        return (1 << e) - 1;
    endfunction

    function automatic int exp_bias(input int e);
        return (1 << (e - 1)) - 1;
    endfunction

    typedef struct packed {
        logic                          sign;
        logic [DEF_EXPONENT_WIDTH-1:0] exponent;
        logic [DEF_MANTISSA_WIDTH-1:0] mantissa;
        logic [DEF_ROUNDING_BITS-1:0]  rounding_bits;
        logic                          zero;
        logic                          subnormal;
        logic                          overflow;
    } beat_t;

endpackage

// File: rtl/leading_zero_counter.sv
// leading_zero_counter: combinational priority encoder, returns WIDTH for an all-zero value
module leading_zero_counter
    import accum_fp_pkg::*;
#(
    parameter int WIDTH = 48,
    parameter int CW    = lzc_width(WIDTH)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CW-1:0]    count
);

    // Scan upward so the highest set bit is the last one to win.
    always_comb begin
        count = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++)
            if (value[i]) count = CW'(WIDTH - 1 - i);
    end

endmodule

// File: rtl/accum_normalizer.sv
// accum_normalizer: two-stage leading-one normaliser and classifier feeding result_rounder
module accum_normalizer
    import accum_fp_pkg::*;
#(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23,
    parameter int ROUNDING_BITS  = 3,
    parameter int ACC_WIDTH      = 48
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_sign,
    input  logic [EXPONENT_WIDTH+1:0]   in_exponent,
    input  logic [ACC_WIDTH-1:0]        in_magnitude,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_sign,
    output logic [EXPONENT_WIDTH-1:0]   out_exponent,
    output logic [MANTISSA_WIDTH-1:0]   out_mantissa,
    output logic [ROUNDING_BITS-1:0]    out_rounding_bits,
    output logic                        out_zero,
    output logic                        out_subnormal,
    output logic                        out_overflow
);

    localparam int LW  = lzc_width(ACC_WIDTH);
    localparam int XW  = EXPONENT_WIDTH + 2;
    localparam int PAD = MANTISSA_WIDTH + ROUNDING_BITS;
    localparam int FW  = ACC_WIDTH + PAD;
    localparam logic signed [XW-1:0] ZERO     = '0;
    localparam logic signed [XW-1:0] ONE      = XW'(1);
    localparam logic signed [XW-1:0] ALL_ONES = XW'(exp_all_ones(EXPONENT_WIDTH));
    localparam logic signed [XW-1:0] EXP_MIN  = {1'b1, {(XW-1){1'b0}}};
    localparam logic signed [XW:0]   ONE_W    = (XW+1)'(1);
    localparam logic signed [XW:0]   ACC_W    = (XW+1)'(ACC_WIDTH);

    typedef struct packed {
        logic                      sign;
        logic [EXPONENT_WIDTH-1:0] exponent;
        logic [MANTISSA_WIDTH-1:0] mantissa;
        logic [ROUNDING_BITS-1:0]  rounding_bits;
        logic                      zero;
        logic                      subnormal;
        logic                      overflow;
    } norm_beat_t;

    logic                   s1_valid, s1_sign, s1_zero;
    logic [ACC_WIDTH-1:0]   s1_mag;
    logic [LW-1:0]          s1_lz;
    logic signed [XW-1:0]   s1_exp_in, s1_norm_exp;
    logic [LW-1:0]          lz;
    logic signed [XW:0]     norm_wide;
    logic signed [XW-1:0]   norm_exp;
    logic                   s1_adv, s2_adv;
    logic                   ovf, normal, sub, exp_pos;
    logic [LW-1:0]          lsh, rsh;
    logic signed [XW:0]     rsh_wide;
    logic [2*ACC_WIDTH-2:0] wide;
    logic [FW-2:0]          fw;
    norm_beat_t             nxt, out_beat;

    leading_zero_counter #(.WIDTH(ACC_WIDTH)) u_lzc (.value(in_magnitude), .count(lz));

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    // Stage-1 exponent adjust, clamped to the most negative code instead of wrapping.
    always_comb begin
        norm_wide = $signed({in_exponent[XW-1], in_exponent}) - $signed({1'b0, lz});
        norm_exp  = (norm_wide[XW] != norm_wide[XW-1]) ? EXP_MIN : norm_wide[XW-1:0];
    end

    // Stage-2 classification, alignment shift and guard/round/sticky extraction.
    always_comb begin
        ovf      = !s1_zero && (s1_norm_exp >= ALL_ONES);
        normal   = !s1_zero && !ovf && (s1_norm_exp >= ONE);
        sub      = !s1_zero && !ovf && !normal;
        exp_pos  = s1_exp_in > ZERO;
        rsh_wide = ONE_W - $signed({s1_exp_in[XW-1], s1_exp_in});
        lsh      = normal ? s1_lz : (exp_pos ? LW'(s1_exp_in - ONE) : '0);
        rsh      = (sub && !exp_pos) ? ((rsh_wide >= ACC_W) ? LW'(ACC_WIDTH) : LW'(rsh_wide)) : '0;
        wide     = (2*ACC_WIDTH-1)'(({s1_mag, {ACC_WIDTH{1'b0}}} << lsh) >> rsh);
        fw       = {wide[2*ACC_WIDTH-2:ACC_WIDTH], {PAD{1'b0}}};
        nxt.sign          = s1_sign;
        nxt.exponent      = normal ? s1_norm_exp[EXPONENT_WIDTH-1:0] : (ovf ? '1 : '0);
        nxt.mantissa      = (normal || sub) ? fw[FW-2 -: MANTISSA_WIDTH] : '0;
        nxt.rounding_bits = (normal || sub) ? {fw[FW-2-MANTISSA_WIDTH -: ROUNDING_BITS-1],
                                               |fw[ACC_WIDTH-1:0] | |wide[ACC_WIDTH-1:0]} : '0;
        nxt.zero          = s1_zero;
        nxt.subnormal     = sub;
        nxt.overflow      = ovf;
    end

    // Two-register pipeline; each stage loads only when its successor frees up.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_sign     <= 1'b0;
            s1_zero     <= 1'b0;
            s1_mag      <= '0;
            s1_lz       <= '0;
            s1_exp_in   <= '0;
            s1_norm_exp <= '0;
            out_valid   <= 1'b0;
            out_beat    <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_sign     <= in_sign;
                    s1_zero     <= in_magnitude == '0;
                    s1_mag      <= in_magnitude;
                    s1_lz       <= lz;
                    s1_exp_in   <= in_exponent;
                    s1_norm_exp <= norm_exp;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) out_beat <= nxt;
            end
        end
    end

    assign out_sign          = out_beat.sign;
    assign out_exponent      = out_beat.exponent;
    assign out_mantissa      = out_beat.mantissa;
    assign out_rounding_bits = out_beat.rounding_bits;
    assign out_zero          = out_beat.zero;
    assign out_subnormal     = out_beat.subnormal;
    assign out_overflow      = out_beat.overflow;

endmodule
